// File: rtl/dds_pkg.sv
// Shared constants and state type for the DDS SPI DAC output stage.
package dds_pkg;

    localparam int DDS_M        = 12;
    localparam int DDS_CFG_BITS = 4;
    localparam int DDS_FRAME    = DDS_CFG_BITS + DDS_M;

    // Channel A, unbuffered Vref, gain 1x, output active.
    localparam logic [DDS_CFG_BITS-1:0] DDS_CFG = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CS_HOLD,
        GAP,
        LATCH
    } dac_state_t;

endpackage

// File: rtl/dds_sck_tick.sv
// Prescaler: one-cycle tick every CLK_DIV clocks, restarted whenever the FSM changes state.
module dds_sck_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int             CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick_o = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dds_spi_dac.sv
// Captures DDS samples, serialises them as MCP4921-style SPI frames and pulses LDAC after each.
// A one-deep pending buffer absorbs samples arriving while a frame is in flight.
module dds_spi_dac
    import dds_pkg::*;
#(
    parameter int                    M        = DDS_M,
    parameter int                    CFG_BITS = DDS_CFG_BITS,
    parameter logic [CFG_BITS-1:0]   CFG      = CFG_BITS'(DDS_CFG),
    parameter int                    CLK_DIV  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] sample_i,
    input  logic         sample_valid_i,
    output logic         busy_o,
    output logic         drop_o,
    output logic         dac_cs_n,
    output logic         dac_sck,
    output logic         dac_sdi,
    output logic         dac_ldac_n
);

    localparam int            FRAME    = CFG_BITS + M;
    localparam int            BW       = $clog2(FRAME + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);

    dac_state_t       state_q, state_d;
    logic [FRAME-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             phase_q, phase_d;
    logic [M-1:0]     pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             cs_n_q, cs_n_d;
    logic             sck_q, sck_d;
    logic             sdi_q, sdi_d;
    logic             ldac_n_q, ldac_n_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;
    logic             tick;
    logic             state_change;

    assign state_change = (state_d != state_q);

    dds_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_change),
        .tick_o  (tick)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cs_n_d      = cs_n_q;
        sck_d       = sck_q;
        sdi_d       = sdi_q;
        ldac_n_d    = ldac_n_q;
        busy_d      = busy_q;
        drop_d      = 1'b0;

        // Any strobe outside IDLE lands in the buffer; newest sample wins.
        if ((state_q != IDLE) && sample_valid_i) begin
            pend_d      = sample_i;
            pend_full_d = 1'b1;
            drop_d      = pend_full_q;
        end

        case (state_q)
            IDLE: begin
                if (pend_full_q || sample_valid_i) begin
                    if (pend_full_q) begin
                        shreg_d     = {CFG, pend_q};
                        pend_full_d = sample_valid_i;
                        if (sample_valid_i) begin
                            pend_d = sample_i;
                        end
                    end else begin
                        shreg_d = {CFG, sample_i};
                    end
                    state_d = SHIFT;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    sdi_d   = shreg_d[FRAME-1];
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sck_d   = 1'b1;
                    end else begin
                        // Rotating keeps every register bit live; the wrapped bit is never sent.
                        shreg_d = {shreg_q[FRAME-2:0], shreg_q[FRAME-1]};
                        phase_d = 1'b0;
                        sck_d   = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d = CS_HOLD;
                            sdi_d   = 1'b0;
                        end else begin
                            bit_d = bit_q + BW'(1);
                            sdi_d = shreg_q[FRAME-2];
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d  = LATCH;
                    ldac_n_d = 1'b0;
                end
            end
            LATCH: begin
                if (tick) begin
                    state_d  = IDLE;
                    ldac_n_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_q       <= '0;
            phase_q     <= 1'b0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b0;
            sdi_q       <= 1'b0;
            ldac_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_q       <= bit_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cs_n_q      <= cs_n_d;
            sck_q       <= sck_d;
            sdi_q       <= sdi_d;
            ldac_n_q    <= ldac_n_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    assign busy_o     = busy_q;
    assign drop_o     = drop_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_sck    = sck_q;
    assign dac_sdi    = sdi_q;
    assign dac_ldac_n = ldac_n_q;

endmodule

// File: tb/tb_dds_spi_dac.sv
// Scoreboard bench: stimulus pushes expected SPI frames, per-instance monitors decode and compare.
module tb_dds_spi_dac;
    import dds_pkg::*;

    localparam int F = DDS_FRAME;

    typedef struct {
        logic [15:0] frame;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] s0, s1;
    logic        v0, v1;
    logic [1:0]  busy_w, drop_w, cs_n_w, sck_w, sdi_w, ldac_w;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   drops[2];
    int   last_drop[2];
    int   aborted[2];
    bit   abort_ok = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dds_spi_dac #(.CLK_DIV(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_i(s0), .sample_valid_i(v0),
        .busy_o(busy_w[0]), .drop_o(drop_w[0]), .dac_cs_n(cs_n_w[0]),
        .dac_sck(sck_w[0]), .dac_sdi(sdi_w[0]), .dac_ldac_n(ldac_w[0])
    );

    dds_spi_dac #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_i(s1), .sample_valid_i(v1),
        .busy_o(busy_w[1]), .drop_o(drop_w[1]), .dac_cs_n(cs_n_w[1]),
        .dac_sck(sck_w[1]), .dac_sdi(sdi_w[1]), .dac_ldac_n(ldac_w[1])
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h at cycle %0d", name, act, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse(input int k, input logic [11:0] d, input int c);
        wait_to(c);
        if (k == 0) begin s0 = d; v0 = 1'b1; end
        else        begin s1 = d; v1 = 1'b1; end
        step();
        v0 = 1'b0;
        v1 = 1'b0;
        s0 = ~d;
        s1 = ~d;
    endtask

    task automatic push(input int k, input logic [15:0] fr, input int start);
        exp_t e;
        e.frame = fr;
        e.start = start;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Decodes frames on the SPI pins of instance k and checks them against the queue.
    task automatic mon(input int k);
        int          div;
        bit          in_f;
        int          start, bits, ld_exp, ld_start;
        logic [15:0] fr;
        logic        hold, psdi;
        logic        pcs, psck, pld;
        bit          stab, exp_ld;
        exp_t        e;
        div = (k == 0) ? 4 : 1;
        in_f = 0; start = 0; bits = 0; ld_exp = 0; ld_start = 0;
        fr = '0; hold = 0; psdi = 0; pcs = 1; psck = 0; pld = 1; stab = 0; exp_ld = 0;
        forever begin
            @(negedge clk);
            if (pcs && !cs_n_w[k]) begin
                in_f = 1; start = cyc; bits = 0; fr = '0; stab = 0;
            end
            if (in_f && !psck && sck_w[k]) begin
                fr   = {fr[14:0], sdi_w[k]};
                bits++;
                hold = sdi_w[k];
                if (sdi_w[k] !== psdi) stab = 1;
            end else if (in_f && sck_w[k] && (sdi_w[k] !== hold)) begin
                stab = 1;
            end
            if (!pcs && cs_n_w[k] && in_f) begin
                in_f = 0;
                if ((bits != F) && abort_ok) begin
                    aborted[k]++;
                    $display("info inst%0d aborted frame with %0d bits at cycle %0d", k, bits, cyc);
                end else if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame inst%0d: got 0x%0h, want no frame", k, fr);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("frame%0d", k), int'(fr), int'(e.frame));
                    check($sformatf("bits%0d", k), bits, F);
                    check($sformatf("cs_low_len%0d", k), cyc - start, (2 * F + 1) * div);
                    if (e.start >= 0) check($sformatf("cs_fall_cycle%0d", k), start, e.start);
                    check($sformatf("sdi_stable%0d", k), int'(stab), 0);
                    exp_ld = 1;
                    ld_exp = start + (2 * F + 2) * div;
                end
            end
            if (pld && !ldac_w[k]) begin
                ld_start = cyc;
                if (!exp_ld) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ldac inst%0d: got pulse at cycle %0d, want none", k, cyc);
                end else begin
                    check($sformatf("ldac_fall_cycle%0d", k), cyc, ld_exp);
                end
            end
            if (!pld && ldac_w[k]) begin
                if (exp_ld) check($sformatf("ldac_len%0d", k), cyc - ld_start, div);
                exp_ld = 0;
            end
            pcs  = cs_n_w[k];
            psck = sck_w[k];
            pld  = ldac_w[k];
            psdi = sdi_w[k];
        end
    endtask

    initial begin
        drops     = '{0, 0};
        last_drop = '{-1, -1};
        aborted   = '{0, 0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (drop_w[k] === 1'b1) begin
                    drops[k]++;
                    last_drop[k] = cyc;
                end
            end
        end
    end

    initial begin
        int c0, c1, dsnap, asnap;
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; s0 = '0; s1 = '0;
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_outputs%0d", k),
                  int'({cs_n_w[k], sck_w[k], sdi_w[k], ldac_w[k], busy_w[k], drop_w[k]}),
                  int'(6'b100100));
        end
        rst_n = 1'b1;
        step();
        fork
            mon(0);
            mon(1);
        join_none

        // Single frame with cycle-accurate CS/LDAC/busy timing.
        c0 = cyc + 2;
        wait_to(c0);
        push(0, 16'h3A5C, c0 + 1);
        s0 = 12'hA5C; v0 = 1'b1;
        check("t1_busy_c0", int'(busy_w[0]), 0);
        step();
        v0 = 1'b0; s0 = 12'h3C3;
        check("t1_cs_c1", int'(cs_n_w[0]), 0);
        check("t1_busy_c1", int'(busy_w[0]), 1);
        wait_to(c0 + 132); check("t1_cs_c132", int'(cs_n_w[0]), 0);
        wait_to(c0 + 133); check("t1_cs_c133", int'(cs_n_w[0]), 1);
        wait_to(c0 + 140); check("t1_ldac_c140", int'({ldac_w[0], busy_w[0]}), 1);
        wait_to(c0 + 141); check("t1_idle_c141", int'({ldac_w[0], busy_w[0]}), 2);

        // Boundary words.
        c0 = cyc + 2;
        push(0, 16'h3000, c0 + 1);
        pulse(0, 12'h000, c0);
        push(0, 16'h3FFF, c0 + 146);
        pulse(0, 12'hFFF, c0 + 145);
        wait_to(c0 + 300);

        // Back-to-back through the pending buffer.
        c0 = cyc + 2;
        dsnap = drops[0];
        push(0, 16'h3456, c0 + 1);
        push(0, 16'h3123, c0 + 142);
        pulse(0, 12'h456, c0);
        pulse(0, 12'h123, c0 + 50);
        wait_to(c0 + 290);
        check("t3_no_drop", drops[0] - dsnap, 0);

        // Overrun: newest pending sample wins, one drop pulse.
        c0 = cyc + 2;
        dsnap = drops[0];
        push(0, 16'h3111, c0 + 11);
        push(0, 16'h3444, c0 + 152);
        pulse(0, 12'h111, c0 + 10);
        pulse(0, 12'h222, c0 + 20);
        pulse(0, 12'h444, c0 + 30);
        wait_to(c0 + 33);
        check("t4_drop_count", drops[0] - dsnap, 1);
        check("t4_drop_cycle", last_drop[0], c0 + 31);
        wait_to(c0 + 300);

        // Reset during bit 7 aborts the frame and empties the pending buffer.
        abort_ok = 1'b1;
        asnap = aborted[0];
        c0 = cyc + 2;
        pulse(0, 12'h0A5, c0);
        pulse(0, 12'h777, c0 + 20);
        wait_to(c0 + 50);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t5_after_reset", int'({cs_n_w[0], sck_w[0], ldac_w[0], busy_w[0]}), int'(4'b1010));
        wait_to(c0 + 200);
        abort_ok = 1'b0;
        check("t5_aborted", aborted[0] - asnap, 1);
        c1 = cyc + 2;
        push(0, 16'h35A3, c1 + 1);
        pulse(0, 12'h5A3, c1);
        wait_to(c1 + 150);

        // CLK_DIV=1: strobe coincident with the IDLE launch of a pending sample.
        c0 = cyc + 2;
        push(1, 16'h3ABC, c0 + 1);
        push(1, 16'h30F0, c0 + 37);
        push(1, 16'h300F, c0 + 73);
        pulse(1, 12'hABC, c0);
        pulse(1, 12'h0F0, c0 + 5);
        wait_to(c0 + 35); check("t6_busy_c35", int'(busy_w[1]), 1);
        wait_to(c0 + 36); check("t6_idle_c36", int'(busy_w[1]), 0);
        pulse(1, 12'h00F, c0 + 36);
        check("t6_cs_c37", int'(cs_n_w[1]), 0);
        wait_to(c0 + 120);
        check("t6_no_drop", drops[1], 0);

        for (int i = 0; i < 500 && (q0.size() != 0 || q1.size() != 0); i++) step();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
